// File: rtl/br_pre_ctrl_sched_pkg.sv
// lmac_br_pkg: shared types and constants for the bridge pre-control read
// scheduler.
//   - control word field positions (length and flags)
//   - scheduler state encoding
//   - the tagged beat that travels through the output skid buffer
//   - last_be_f(): byte-enable mask for a final beat holding rem bytes
package lmac_br_pkg;

    localparam int LEN_LSB    = 0;
    localparam int LEN_W      = 16;
    localparam int FLAG_LSB   = 16;
    localparam int FLAG_W     = 24;
    localparam int BEAT_BYTES = 8;
    localparam int BEAT_DW    = BEAT_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CTRL_WAIT = 2'd1,
        DATA      = 2'd2
    } sched_state_e;

    // Flags ride with every beat. The next packet's control word can be
    // decoded while beats of the previous packet are still queued, so a
    // single per-packet flags register would not be enough.
    typedef struct packed {
        logic [FLAG_W-1:0]     flags;
        logic [BEAT_BYTES-1:0] be;
        logic                  eop;
        logic                  sop;
        logic [BEAT_DW-1:0]    data;
    } beat_t;

    // rem = len[2:0]. Zero means the final beat is full.
    function automatic logic [BEAT_BYTES-1:0] last_be_f(input logic [2:0] rem);
        logic [BEAT_BYTES-1:0] one;
        one = {{(BEAT_BYTES-1){1'b0}}, 1'b1};
        if (rem == 3'd0) return '1;
        return (one << rem) - one;
    endfunction

endpackage

// File: rtl/br_pre_ctrl_sched_skid2.sv
// br_skid2: two-entry valid/ready buffer on the output side of the
// scheduler.
//   clk, reset_       read clock, async active-low reset
//   i_push, i_data    write one entry; the caller guarantees there is room
//   i_pop             downstream ready; ignored when the buffer is empty
//   o_valid, o_data   head entry; held stable until it is popped
//   o_count           occupancy, 0..2
module br_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop   = i_pop & (r_cnt != 2'd0);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            // Push and pop together leave the occupancy unchanged.
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/br_pre_ctrl_sched.sv
// br_pre_ctrl_sched: read-side scheduler for the bridge pre-control FIFO and
// its companion packet data FIFO.
//   For each packet it pops one control word (len + flags), issues exactly
//   ceil(len/8) data FIFO reads, tags every returned word (sop/eop/be/flags)
//   and presents the result as a valid/ready beat stream.
// Ports:
//   clk, reset_                       read clock, async active-low reset
//   sched_en                          allow new packets to start
//   ctrl_empty/ctrl_rdreq/ctrl_q      pre-ctrl FIFO read port (latency 1)
//   ctrl_usedw                        pre-ctrl fill level, status only
//   data_empty/data_rden/data_q       data FIFO read port (latency 1)
//   out_valid/out_ready/out_*         output beat stream
//   err_len                           pulse when a zero or oversize length is popped
//   pkt_cnt                           packets whose eop beat was accepted
module br_pre_ctrl_sched
    import lmac_br_pkg::*;
#(
    parameter int CTRL_W  = 40,
    parameter int DATA_W  = 64,
    parameter int PTR     = 10,
    parameter int MAX_LEN = 9600
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  sched_en,
    input  logic                  ctrl_empty,
    output logic                  ctrl_rdreq,
    input  logic [CTRL_W-1:0]     ctrl_q,
    input  logic [PTR:0]          ctrl_usedw,
    input  logic                  data_empty,
    output logic                  data_rden,
    input  logic [DATA_W-1:0]     data_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [DATA_W/8-1:0]   out_be,
    output logic [FLAG_W-1:0]     out_flags,
    output logic                  err_len,
    output logic [15:0]           pkt_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    sched_state_e          r_state, w_state_nx;
    logic [13:0]           r_beats_left;
    logic                  r_first;
    logic [BEAT_BYTES-1:0] r_last_be;
    logic [FLAG_W-1:0]     r_flags;
    logic                  r_rd_vld;
    logic                  r_rd_sop;
    logic                  r_rd_eop;
    logic [BEAT_BYTES-1:0] r_rd_be;
    logic [FLAG_W-1:0]     r_rd_flags;
    logic [15:0]           r_pkt_cnt;

    logic [LEN_W-1:0]      w_len;
    logic [FLAG_W-1:0]     w_cq_flags;
    logic [13:0]           w_cq_beats;
    logic                  w_cw;
    logic [13:0]           w_left;
    logic [BEAT_BYTES-1:0] w_lbe;
    logic [FLAG_W-1:0]     w_flags;
    logic                  w_first;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [2:0]            w_pend;
    logic                  w_rd_ok;
    logic                  w_last_rd;
    logic                  w_ctrl_go;
    logic                  w_ctrl_rdreq;
    logic                  w_err;
    beat_t                 w_push_beat;
    beat_t                 w_head;
    logic                  w_head_vld;
    logic                  w_unused_usedw;

    assign w_unused_usedw = ^ctrl_usedw;

    // Control word decode; only meaningful in CTRL_WAIT, when ctrl_q holds
    // the word popped on the previous cycle.
    assign w_len      = ctrl_q[LEN_LSB +: LEN_W];
    assign w_cq_flags = ctrl_q[FLAG_LSB +: FLAG_W];
    assign w_cq_beats = {1'b0, w_len[15:3]} + {13'd0, |w_len[2:0]};
    assign w_cw       = (r_state == CTRL_WAIT);

    // CTRL_WAIT reads the first beat straight from the decoded word, and
    // the last read of a packet can pop the next control word. Together
    // these keep data reads contiguous across packet boundaries, so
    // back-to-back packets stream out with no bubble.
    assign w_left  = w_cw ? w_cq_beats : r_beats_left;
    assign w_lbe   = w_cw ? last_be_f(w_len[2:0]) : r_last_be;
    assign w_flags = w_cw ? w_cq_flags : r_flags;
    assign w_first = w_cw | r_first;

    // Entries held by the skid plus the read in flight must stay within
    // two. A beat leaving the skid this cycle counts as free, which is what
    // allows a steady 1 beat/clk.
    assign w_pop  = w_head_vld & out_ready;
    assign w_pend = {1'b0, w_occ} + {2'b00, r_rd_vld} - {2'b00, w_pop};

    assign w_rd_ok   = (r_state != IDLE) & ~data_empty & (w_left != 14'd0) & (w_pend < 3'd2);
    assign w_last_rd = w_rd_ok & (w_left == 14'd1);
    assign w_ctrl_go = sched_en & ~ctrl_empty & reset_;

    always_comb begin
        w_state_nx   = r_state;
        w_ctrl_rdreq = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ctrl_go) begin
                    w_ctrl_rdreq = 1'b1;
                    w_state_nx   = CTRL_WAIT;
                end
            end
            CTRL_WAIT: begin
                // Oversize packets are flagged but still forwarded: their
                // data is already in the data FIFO.
                w_err = (w_len == '0) | (w_len > MAX_LEN_L);
                if (w_len == '0) begin
                    w_state_nx = IDLE;
                end else if (w_last_rd) begin
                    w_ctrl_rdreq = w_ctrl_go;
                    w_state_nx   = w_ctrl_go ? CTRL_WAIT : IDLE;
                end else begin
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                if (w_last_rd) begin
                    w_ctrl_rdreq = w_ctrl_go;
                    w_state_nx   = w_ctrl_go ? CTRL_WAIT : IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign ctrl_rdreq = w_ctrl_rdreq;
    assign data_rden  = w_rd_ok;
    assign err_len    = w_err;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_first      <= 1'b0;
            r_last_be    <= '0;
            r_flags      <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_sop     <= 1'b0;
            r_rd_eop     <= 1'b0;
            r_rd_be      <= '0;
            r_rd_flags   <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nx;

            if (w_cw) begin
                r_last_be    <= w_lbe;
                r_flags      <= w_cq_flags;
                r_first      <= ~w_rd_ok;
                r_beats_left <= w_left - {13'd0, w_rd_ok};
            end else if (w_rd_ok) begin
                r_first      <= 1'b0;
                r_beats_left <= r_beats_left - 14'd1;
            end

            // Tags are fixed when the read issues; the word arrives a cycle
            // later, possibly after the next packet's control word is decoded.
            r_rd_vld <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_sop   <= w_first;
                r_rd_eop   <= (w_left == 14'd1);
                r_rd_be    <= (w_left == 14'd1) ? w_lbe : '1;
                r_rd_flags <= w_flags;
            end

            if (w_pop & w_head.eop) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    always_comb begin
        w_push_beat       = '0;
        w_push_beat.flags = r_rd_flags;
        w_push_beat.be    = r_rd_be;
        w_push_beat.eop   = r_rd_eop;
        w_push_beat.sop   = r_rd_sop;
        w_push_beat.data  = BEAT_DW'(data_q);
    end

    br_skid2 #(.W($bits(beat_t))) u_skid (
        .clk     (clk),
        .reset_  (reset_),
        .i_push  (r_rd_vld),
        .i_data  (w_push_beat),
        .i_pop   (out_ready),
        .o_valid (w_head_vld),
        .o_data  (w_head),
        .o_count (w_occ)
    );

    assign out_valid = w_head_vld;
    assign out_data  = DATA_W'(w_head.data);
    assign out_sop   = w_head.sop;
    assign out_eop   = w_head.eop;
    assign out_be    = w_head.be;
    assign out_flags = w_head.flags;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_br_pre_ctrl_sched.sv
// Bench for br_pre_ctrl_sched: both FIFOs are modelled as queues with one
// cycle of read latency, and every pushed packet is expanded arithmetically
// into its expected beats (scoreboard) from its length and flags.
module tb_br_pre_ctrl_sched;

    logic        clk = 1'b0;
    logic        reset_;
    logic        sched_en;
    logic        ctrl_empty;
    logic        ctrl_rdreq;
    logic [39:0] ctrl_q;
    logic [10:0] ctrl_usedw;
    logic        data_empty;
    logic        data_rden;
    logic [63:0] data_q;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_be;
    logic [23:0] out_flags;
    logic        err_len;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    br_pre_ctrl_sched dut (
        .clk        (clk),
        .reset_     (reset_),
        .sched_en   (sched_en),
        .ctrl_empty (ctrl_empty),
        .ctrl_rdreq (ctrl_rdreq),
        .ctrl_q     (ctrl_q),
        .ctrl_usedw (ctrl_usedw),
        .data_empty (data_empty),
        .data_rden  (data_rden),
        .data_q     (data_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_be     (out_be),
        .out_flags  (out_flags),
        .err_len    (err_len),
        .pkt_cnt    (pkt_cnt)
    );

    logic [39:0] cq [$];
    logic [63:0] dq [$];
    logic [98:0] exp_q [$];
    int n_chk = 0, n_fail = 0;
    int rden_cnt = 0, accepted = 0, dw_pushed = 0;
    int err_seen = 0, exp_err = 0, exp_pkts = 0;
    int stall_left = 0, rdy_mode = 0, run_len = 0, max_run = 0;
    logic pend_c = 1'b0, pend_d = 1'b0, prev_hold = 1'b0, tog = 1'b0;
    logic [98:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [98:0] dut_beat();
        return {out_valid, out_flags, out_be, out_eop, out_sop, out_data};
    endfunction

    function automatic logic [117:0] all_outs();
        return {out_valid, out_data, out_sop, out_eop, out_be, out_flags,
                err_len, pkt_cnt, ctrl_rdreq, data_rden};
    endfunction

    task automatic refresh();
        ctrl_empty = (cq.size() == 0);
        data_empty = (dq.size() == 0) || (stall_left > 0);
        ctrl_usedw = 11'(cq.size());
    endtask

    // Reference: a packet of len bytes is ceil(len/8) beats, sop on the first,
    // eop on the last, the last one carrying len%8 low byte enables.
    task automatic push_pkt(input int len, input logic [23:0] fl);
        int nb;
        logic [63:0] d;
        logic [7:0] be;
        logic [15:0] l16;
        nb = (len + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            d = {$urandom, $urandom};
            dq.push_back(d);
            dw_pushed++;
            be = 8'hFF;
            if (i == nb - 1 && (len % 8) != 0) be = 8'((1 << (len % 8)) - 1);
            exp_q.push_back({1'b1, fl, be, (i == nb - 1), (i == 0), d});
        end
        l16 = 16'(len);
        cq.push_back({fl, l16});
        if (len == 0 || len > 9600) exp_err++;
        if (len != 0) exp_pkts++;
        refresh();
    endtask

    task automatic cyc();
        logic acc;
        logic [98:0] cur;
        @(negedge clk);
        cur = dut_beat();
        pend_c = 1'b0;
        pend_d = 1'b0;
        if (reset_) begin
            if (ctrl_rdreq) begin
                chk("rdreq_when_empty", ctrl_empty, 1'b0);
                pend_c = 1'b1;
            end
            if (data_rden) begin
                chk("rden_when_empty", data_empty, 1'b0);
                pend_d = 1'b1;
                rden_cnt++;
            end
            if (err_len) err_seen++;
            if (prev_hold) chk("stall_hold", cur, prev_beat);
            acc = out_valid & out_ready;
            if (acc) begin
                accepted++;
                chk("beat_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) chk("beat", cur, exp_q.pop_front());
            end
            if (data_rden) chk("outstanding_le2", ((rden_cnt - accepted) <= 2), 1'b1);
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            prev_hold = out_valid & ~out_ready;
            prev_beat = cur;
        end
        @(posedge clk);
        #1;
        if (pend_c && cq.size() != 0) ctrl_q = cq.pop_front();
        if (pend_d && dq.size() != 0) data_q = dq.pop_front();
        if (stall_left > 0) stall_left--;
        case (rdy_mode)
            1: out_ready = 1'b1;
            2: begin tog = ~tog; out_ready = tog; end
            3: begin
                out_ready = 1'($urandom_range(0, 1));
                sched_en  = ($urandom_range(0, 3) != 0);
                if (stall_left == 0 && $urandom_range(0, 15) == 0)
                    stall_left = $urandom_range(1, 3);
            end
            default: out_ready = 1'b0;
        endcase
        refresh();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30000 && (exp_q.size() != 0 || cq.size() != 0); i++) cyc();
        repeat (6) cyc();
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 16'(exp_pkts));
        chk({tag, "_rden_total"}, rden_cnt, dw_pushed);
        chk({tag, "_err_len"}, err_seen, exp_err);
    endtask

    initial begin
        int a0;
        reset_    = 1'b0;
        sched_en  = 1'b1;
        out_ready = 1'b0;
        ctrl_q    = '0;
        data_q    = '0;
        refresh();
        repeat (3) cyc();
        chk("reset_outs", all_outs(), '0);
        reset_   = 1'b1;
        rdy_mode = 1;

        // single 64-byte packet
        push_pkt(64, 24'hA5A5A5);
        drain("len64");

        // partial last beat, single-beat packet
        push_pkt(13, 24'h000013);
        push_pkt(1, 24'h000001);
        drain("len13_len1");

        // zero length then a full 8-byte beat
        push_pkt(0, 24'hDEAD00);
        push_pkt(8, 24'h000008);
        drain("len0_len8");

        // back-to-back packets, no bubble
        max_run = 0;
        push_pkt(16, 24'h111111);
        push_pkt(16, 24'h222222);
        drain("b2b");
        chk("b2b_no_bubble", max_run, 4);

        // ready toggling plus data FIFO empty mid-packet
        rdy_mode = 2;
        push_pkt(64, 24'h5A5A5A);
        a0 = accepted;
        for (int i = 0; i < 200 && accepted < a0 + 3; i++) cyc();
        stall_left = 3;
        refresh();
        drain("stall");
        rdy_mode = 1;

        // sched_en dropped mid-packet
        push_pkt(40, 24'h0A0A0A);
        push_pkt(40, 24'h0B0B0B);
        for (int i = 0; i < 50 && cq.size() > 1; i++) cyc();
        sched_en = 1'b0;
        repeat (40) cyc();
        chk("sched_off_ctrl_kept", cq.size(), 1);
        chk("sched_off_pkt_done", pkt_cnt, 16'(exp_pkts - 1));
        sched_en = 1'b1;
        drain("sched_off");

        // length boundaries
        push_pkt(9600, 24'h009600);
        push_pkt(9601, 24'h009601);
        drain("max_len");

        // randomized mix
        rdy_mode = 3;
        for (int p = 0; p < 30; p++)
            push_pkt(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200)), 24'($urandom));
        drain("random");
        rdy_mode = 1;
        sched_en = 1'b1;

        // reset in the middle of an 8-beat packet
        push_pkt(64, 24'h777777);
        a0 = accepted;
        for (int i = 0; i < 100 && accepted < a0 + 2; i++) cyc();
        reset_ = 1'b0;
        #2;
        chk("reset_async_outs", all_outs(), '0);
        cq.delete();
        dq.delete();
        exp_q.delete();
        pend_c = 1'b0; pend_d = 1'b0; prev_hold = 1'b0;
        stall_left = 0;
        ctrl_q = '0;
        data_q = '0;
        rden_cnt = 0; accepted = 0; dw_pushed = 0; exp_pkts = 0;
        push_pkt(24, 24'h333333);
        #1;
        chk("reset_rdreq_gated", ctrl_rdreq, 1'b0);
        repeat (2) cyc();
        reset_ = 1'b1;
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
